acc_requant: RTL and testbench

Post-accumulation requantization stage. It consumes the 10-channel, 32-bit signed accumulator results (bias already folded in) produced by the accumulator register stage. Each channel is scaled by a fixed-point multiplier, round-shifted, optionally ReLU-clipped and saturated to int8. The int8 vector is emitted to the next layer's input buffer or to the result interface, over a valid/ready handshake at one vector per cycle.

---
 rtl/acc_requant_pkg.sv | 33 +++
 rtl/requant_lane.sv | 59 +++++
 rtl/acc_requant.sv | 127 ++++++++++++
 tb/tb_acc_requant.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_requant_pkg.sv
// acc_requant_pkg: shared constants, datapath types and the int8 saturation helper
// used by the requantization stage (acc_requant) and its per-channel lane (requant_lane).
package acc_requant_pkg;

    localparam int unsigned N_CH    = 10;
    localparam int unsigned IN_W    = 32;
    localparam int unsigned MULT_W  = 16;
    localparam int unsigned SHIFT_W = 5;
    localparam int unsigned OUT_W   = 8;
    localparam int unsigned PROD_W  = IN_W + MULT_W;
    localparam int unsigned IDX_W   = 4;

    typedef logic signed [IN_W-1:0]   acc_t;
    typedef logic signed [OUT_W-1:0]  q_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    localparam prod_t QMax = prod_t'((1 <<< (OUT_W - 1)) - 1);
    localparam prod_t QMin = -QMax - prod_t'(1);

    // Clamp a full-width result into the signed output range.
    function automatic q_t sat_q(input prod_t v);
        q_t r;
        if (v > QMax) begin
            r = q_t'(QMax);
        end else if (v < QMin) begin
            r = q_t'(QMin);
        end else begin
            r = q_t'(v);
        end
        return r;
    endfunction

endpackage

// File: rtl/requant_lane.sv
// requant_lane: one channel of the requantization datapath.
//   S1 register: full-width signed product i_res * i_mult.
//   S2 register: round-half-up arithmetic shift, int8 saturation, optional ReLU.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_s1_load         load the product register from i_res/i_mult
//   i_res, i_mult     accumulator value and scale multiplier (signed)
//   i_s2_load         load the output register from the S1 product
//   i_shift           shift amount travelling with the S1 product
//   i_relu_en         ReLU enable travelling with the S1 product
//   o_q               S2 int8 result
module requant_lane
    import acc_requant_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_s1_load,
    input  logic [IN_W-1:0]    i_res,
    input  logic [MULT_W-1:0]  i_mult,
    input  logic               i_s2_load,
    input  logic [SHIFT_W-1:0] i_shift,
    input  logic               i_relu_en,
    output logic [OUT_W-1:0]   o_q
);

    prod_t w_prod;
    prod_t w_rnd;
    prod_t w_shr;
    q_t    w_sat;
    q_t    w_q;
    prod_t r_prod;
    q_t    r_q;

    // Both operands are sign-extended to 48 b, so the truncated product is exact.
    assign w_prod = prod_t'($signed(i_res)) * prod_t'($signed(i_mult));

    // Half-LSB rounding bias; the 48 b sum cannot overflow for any legal operand.
    assign w_rnd  = (i_shift == '0) ? '0 : (prod_t'(1) <<< (i_shift - SHIFT_W'(1)));
    assign w_shr  = (r_prod + w_rnd) >>> i_shift;
    assign w_sat  = sat_q(w_shr);
    assign w_q    = (i_relu_en && w_sat[OUT_W-1]) ? '0 : w_sat;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prod <= '0;
            r_q    <= '0;
        end else begin
            if (i_s1_load) begin
                r_prod <= w_prod;
            end
            if (i_s2_load) begin
                r_q <= w_q;
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/acc_requant.sv
// acc_requant: three-stage requantization of a 10-channel int32 accumulator vector to int8.
//   S1 multiply, S2 round/shift/saturate/ReLU (per-channel requant_lane), S3 output register.
//   Each stage has its own valid bit; a stage loads when empty or when its successor loads,
//   so bubbles collapse and throughput is one vector per cycle.
// Optional feature: define ACC_REQUANT_ARGMAX_EN to add the argmax comparator on the S2 values
// and register o_argmax in S3; otherwise o_argmax is tied to 0.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_pre_valid / o_pre_ready    input handshake
//   o_post_valid / i_post_ready  output handshake
//   i_res                        N_CH signed accumulator results
//   i_mult, i_shift, i_relu_en   per-vector scale controls, captured at input fire
//   o_q                          N_CH signed int8 results
//   o_argmax                     index of the largest o_q element (lowest index on ties)
module acc_requant
    import acc_requant_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_pre_valid,
    output logic                       o_pre_ready,
    output logic                       o_post_valid,
    input  logic                       i_post_ready,
    input  logic [N_CH-1:0][IN_W-1:0]  i_res,
    input  logic [MULT_W-1:0]          i_mult,
    input  logic [SHIFT_W-1:0]         i_shift,
    input  logic                       i_relu_en,
    output logic [N_CH-1:0][OUT_W-1:0] o_q,
    output logic [IDX_W-1:0]           o_argmax
);

    logic                       r_s1_valid;
    logic                       r_s2_valid;
    logic                       r_s3_valid;
    logic [SHIFT_W-1:0]         r_s1_shift;
    logic                       r_s1_relu;
    logic [N_CH-1:0][OUT_W-1:0] r_q;
    logic [N_CH-1:0][OUT_W-1:0] w_s2_q;

    logic w_s1_ready;
    logic w_s2_ready;
    logic w_s3_ready;
    logic w_s1_load;
    logic w_s2_load;
    logic w_s3_load;

    assign w_s3_ready = !r_s3_valid || i_post_ready;
    assign w_s2_ready = !r_s2_valid || w_s3_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;

    assign w_s1_load  = i_pre_valid && w_s1_ready;
    assign w_s2_load  = r_s1_valid && w_s2_ready;
    assign w_s3_load  = r_s2_valid && w_s3_ready;

    assign o_pre_ready  = w_s1_ready;
    // Masked during reset so no output fire can happen in the reset cycle.
    assign o_post_valid = r_s3_valid && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s1_shift <= '0;
            r_s1_relu  <= 1'b0;
            r_q        <= '0;
        end else begin
            if (w_s1_ready) r_s1_valid <= i_pre_valid;
            if (w_s2_ready) r_s2_valid <= r_s1_valid;
            if (w_s3_ready) r_s3_valid <= r_s2_valid;
            if (w_s1_load) begin
                r_s1_shift <= i_shift;
                r_s1_relu  <= i_relu_en;
            end
            if (w_s3_load) begin
                r_q <= w_s2_q;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        requant_lane u_lane (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_s1_load (w_s1_load),
            .i_res     (i_res[g]),
            .i_mult    (i_mult),
            .i_s2_load (w_s2_load),
            .i_shift   (r_s1_shift),
            .i_relu_en (r_s1_relu),
            .o_q       (w_s2_q[g])
        );
    end

    assign o_q = r_q;

`ifdef ACC_REQUANT_ARGMAX_EN
    logic [IDX_W-1:0] w_argmax;
    logic [IDX_W-1:0] r_argmax;
    q_t               w_best;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        w_best   = $signed(w_s2_q[0]);
        w_argmax = '0;
        for (int unsigned c = 1; c < N_CH; c++) begin
            if ($signed(w_s2_q[c]) > w_best) begin
                w_best   = $signed(w_s2_q[c]);
                w_argmax = IDX_W'(c);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_argmax <= '0;
        end else if (w_s3_load) begin
            r_argmax <= w_argmax;
        end
    end

    assign o_argmax = r_argmax;
`else
    assign o_argmax = '0;
`endif

endmodule

// File: tb/tb_acc_requant.sv
// tb_acc_requant: directed self-checking bench for acc_requant.
module tb_acc_requant;
    import acc_requant_pkg::*;

    logic                       i_clk = 1'b0;
    logic                       i_rst;
    logic                       i_pre_valid;
    logic                       o_pre_ready;
    logic                       o_post_valid;
    logic                       i_post_ready;
    logic [N_CH-1:0][IN_W-1:0]  i_res;
    logic [MULT_W-1:0]          i_mult;
    logic [SHIFT_W-1:0]         i_shift;
    logic                       i_relu_en;
    logic [N_CH-1:0][OUT_W-1:0] o_q;
    logic [IDX_W-1:0]           o_argmax;

    int n_checks = 0;
    int n_errors = 0;
    int v_res[N_CH];
    int v_exp[N_CH];

    acc_requant dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pre_valid  (i_pre_valid),
        .o_pre_ready  (o_pre_ready),
        .o_post_valid (o_post_valid),
        .i_post_ready (i_post_ready),
        .i_res        (i_res),
        .i_mult       (i_mult),
        .i_shift      (i_shift),
        .i_relu_en    (i_relu_en),
        .o_q          (o_q),
        .o_argmax     (o_argmax)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int am_exp(input int idx);
`ifdef ACC_REQUANT_ARGMAX_EN
        return idx;
`else
        return 0 * idx;
`endif
    endfunction

    task automatic clear_vec();
        for (int c = 0; c < N_CH; c++) begin
            v_res[c] = 0;
            v_exp[c] = 0;
        end
    endtask

    task automatic drive_vec(input int mult, input int shift, input bit relu);
        for (int c = 0; c < N_CH; c++) i_res[c] = v_res[c];
        i_mult    = mult[MULT_W-1:0];
        i_shift   = shift[SHIFT_W-1:0];
        i_relu_en = relu;
    endtask

    // Push one vector into an empty pipeline and check latency, data and argmax.
    task automatic run_vec(input string tag, input int mult, input int shift, input bit relu,
                           input int exp_am);
        int lat;
        drive_vec(mult, shift, relu);
        i_pre_valid = 1'b1;
        #1 check({tag, "_ready"}, int'(o_pre_ready), 1);
        @(negedge i_clk);
        i_pre_valid = 1'b0;
        lat = 1;
        while (!o_post_valid && lat < 10) begin
            @(negedge i_clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        for (int c = 0; c < N_CH; c++) begin
            check($sformatf("%s_q%0d", tag, c), int'($signed(o_q[c])), v_exp[c]);
        end
        check({tag, "_argmax"}, int'(o_argmax), am_exp(exp_am));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sent;
        int got;
        int gaps;
        int stale;

        i_rst        = 1'b1;
        i_pre_valid  = 1'b0;
        i_post_ready = 1'b1;
        i_res        = '0;
        i_mult       = '0;
        i_shift      = '0;
        i_relu_en    = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("rst_post_valid", int'(o_post_valid), 0);
        check("rst_pre_ready", int'(o_pre_ready), 1);
        check("rst_argmax", int'(o_argmax), 0);
        check("rst_q_zero", int'(o_q == '0), 1);
        @(negedge i_clk);

        // 3000 + 2 >>> 2 = 750, saturates
        clear_vec(); v_res[0] = 1000; v_exp[0] = 127;
        run_vec("basic_sat", 3, 2, 1'b0, 0);
        clear_vec(); v_res[1] = -40; v_exp[1] = -40;
        run_vec("basic_neg", 1, 0, 1'b0, 0);
        clear_vec();
        v_res[0] = 6;  v_exp[0] = 2;
        v_res[1] = -6; v_exp[1] = -1;
        v_res[2] = -2; v_exp[2] = 0;
        v_res[3] = 2;  v_exp[3] = 1;
        v_res[4] = 10; v_exp[4] = 3;
        run_vec("round", 1, 2, 1'b0, 4);
        clear_vec();
        v_res[0] = -100000; v_exp[0] = -128;
        v_res[1] = 200;     v_exp[1] = 127;
        v_res[2] = -5;      v_exp[2] = -5;
        v_res[3] = 5;       v_exp[3] = 5;
        run_vec("sat", 1, 0, 1'b0, 1);
        v_exp[0] = 0; v_exp[2] = 0;
        run_vec("relu", 1, 0, 1'b1, 1);
        // -2^32 + 2^30 >>> 31 = floor(-1.5) = -2; 2000 + 2^30 >>> 31 = 0
        clear_vec();
        v_res[0] = int'(32'h8000_0000); v_exp[0] = -2;
        v_res[1] = 1000;                v_exp[1] = 0;
        run_vec("shift31", 2, 31, 1'b0, 1);
        clear_vec();
        v_res[0] = 9;  v_exp[0] = -31;
        v_res[1] = -9; v_exp[1] = 32;
        v_res[2] = -1; v_exp[2] = 4;
        run_vec("negmult", -7, 1, 1'b0, 1);
        clear_vec();
        v_res[0] = 5;  v_exp[0] = 5;
        v_res[1] = 9;  v_exp[1] = 9;
        v_res[2] = 9;  v_exp[2] = 9;
        v_res[3] = -3; v_exp[3] = -3;
        run_vec("am_tie", 1, 0, 1'b0, 1);
        clear_vec();
        run_vec("am_zero", 1, 0, 1'b0, 0);
        for (int c = 0; c < N_CH; c++) begin
            v_res[c] = -10 * (c + 1);
            v_exp[c] = -10 * (c + 1);
        end
        v_res[7] = -1; v_exp[7] = -1;
        run_vec("am_neg", 1, 0, 1'b0, 7);
        for (int c = 0; c < N_CH; c++) begin
            v_res[c] = 50;
            v_exp[c] = 50;
        end
        v_res[9] = 100; v_exp[9] = 100;
        run_vec("am_last", 1, 0, 1'b0, 9);
        repeat (2) @(negedge i_clk);

        // Backpressure: downstream stalled for the first 5 cycles.
        i_post_ready = 1'b0;
        sent = 0;
        got  = 0;
        gaps = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            if (cyc == 5) i_post_ready = 1'b1;
            if (sent < 6) begin
                clear_vec();
                v_res[0] = 10 * (sent + 1);
                v_res[1] = -(sent + 1);
                drive_vec(1, 0, 1'b0);
                i_pre_valid = 1'b1;
            end else begin
                i_pre_valid = 1'b0;
            end
            #1;
            if (cyc < 3) check("bp_ready_fill", int'(o_pre_ready), 1);
            if (cyc == 3) check("bp_accepts", sent, 3);
            if (cyc == 3 || cyc == 4) begin
                check("bp_ready_full", int'(o_pre_ready), 0);
                check("bp_stall_valid", int'(o_post_valid), 1);
                check("bp_stall_q0", int'($signed(o_q[0])), 10);
            end
            if (cyc == 5) check("bp_ready_flow", int'(o_pre_ready), 1);
            if (o_post_valid && i_post_ready) begin
                check("bp_out_q0", int'($signed(o_q[0])), 10 * (got + 1));
                check("bp_out_q1", int'($signed(o_q[1])), -(got + 1));
                got++;
            end else if (got > 0) begin
                gaps++;
            end
            if (i_pre_valid && o_pre_ready) sent++;
            @(negedge i_clk);
        end
        i_pre_valid = 1'b0;
        check("bp_got", got, 6);
        check("bp_gaps", gaps, 0);
        check("bp_sent", sent, 6);
        repeat (2) @(negedge i_clk);

        // Reset with two vectors in flight (S3 and S2).
        clear_vec(); v_res[0] = 55;
        drive_vec(1, 0, 1'b0);
        i_pre_valid = 1'b1;
        @(negedge i_clk);
        v_res[0] = 66;
        drive_vec(1, 0, 1'b0);
        @(negedge i_clk);
        i_pre_valid = 1'b0;
        @(negedge i_clk);
        #1 check("mid_pre_valid", int'(o_post_valid), 1);
        i_rst = 1'b1;
        #1 check("mid_rst_valid", int'(o_post_valid), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("mid_after_valid", int'(o_post_valid), 0);
        check("mid_after_ready", int'(o_pre_ready), 1);
        check("mid_after_q0", int'($signed(o_q[0])), 0);
        stale = 0;
        repeat (8) begin
            @(negedge i_clk);
            if (o_post_valid) stale++;
        end
        check("mid_stale", stale, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
